lfsr_rand_gen: RTL and testbench
================================

Name: lfsr_rand_gen

Overview:
- Parametrised Fibonacci LFSR random source, successor to the 1-bit free-running generator.
- Adds configurable width and taps, seed loading, zero-state lockup protection and multi-bit word output (OUT_W bits per cycle).
- Adds a burst "fill" mode with valid/ready handshake that streams FILL_WORDS random words to the board-initialisation logic of the Game of Life core.

Parameters:
- WIDTH, 16: LFSR state width; minimum 3.
- TAPS, 16'hD008: feedback mask (x^16+x^15+x^13+x^4+1); bit i set means state[i] is XORed into the feedback.
- SEED, 16'hACE1: reset and fallback seed; must be non-zero.
- OUT_W, 8: bits produced per advance; 1 <= OUT_W <= WIDTH.
- FILL_WORDS, 64: words per fill burst; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- seed_load  in  1  load seed_in into the state this cycle.
- seed_in  in  WIDTH  seed value.
- rand_en  in  1  free-run advance enable; honoured only in IDLE.
- fill_start  in  1  start a fill burst; honoured only in IDLE.
- word_ready  in  1  consumer accepts word_out.
- rand_out  out  1  state[WIDTH-1], the next bit to be shifted out.
- word_out  out  OUT_W  state[WIDTH-1 -: OUT_W].
- word_valid  out  1  high throughout FILL.
- word_idx  out  max(1,$clog2(FILL_WORDS))  index of the current fill word.
- fill_busy  out  1  high in FILL.
- fill_done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (async, rst=1): state=SEED, FSM=IDLE, word_idx=0, word_valid=0, fill_busy=0, fill_done=0.
- Single step: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Advance: state <= state stepped OUT_W times, all in one clock.
- word_out and rand_out are combinational slices of the registered state; no extra latency.
- FSM IDLE:
  - rand_en=1 advances the state every cycle.
  - fill_start=1 moves to FILL with word_idx=0; no advance in that cycle.
- FSM FILL:
  - word_valid=1 and fill_busy=1.
  - A handshake (word_valid && word_ready) advances the state.
  - On handshake with word_idx < FILL_WORDS-1: word_idx increments.
  - On handshake with word_idx == FILL_WORDS-1: go to DONE; word_idx returns to 0.
  - word_ready low stalls: word_out held stable, no advance.
  - rand_en and fill_start are ignored.
- FSM DONE: fill_done=1 for exactly one cycle, no advance, then IDLE.
- seed_load has highest priority in any state:
  - state <= (seed_in==0) ? SEED : seed_in.
  - In FILL or DONE it aborts: FSM=IDLE, word_valid=0, word_idx=0, no fill_done pulse.
  - seed_load together with fill_start: the load wins; fill_start is dropped.
- Lockup guard: if the computed next state is all-zero, load SEED instead. This is unreachable with a primitive TAPS and non-zero state; the guard exists for illegal TAPS values.
- rst asserted mid-burst returns everything to reset values immediately.
- Period: 2^WIDTH-1 steps for a primitive TAPS. The word sequence repeats every (2^WIDTH-1)/gcd(OUT_W, 2^WIDTH-1) words.

Decomposition:
- Package lfsr_pkg:
  - FSM state enum (IDLE, FILL, DONE).
  - Default-tap constants for widths 4/8/16/32 (4'hC, 8'hB8, 16'hD008, 32'h80200003).
  - Default seed constant.
- Sub-module lfsr_step: purely combinational single-step next-state, parametrised by WIDTH/TAPS. Chained OUT_W times by a generate loop in lfsr_rand_gen.
- FSM, counter and lockup guard stay in the top module.

Test Plan (WIDTH=4, TAPS=4'hC, SEED=4'h1 unless noted):
- Sequence check, OUT_W=1: rst pulse, then rand_en=1 for 16 cycles -> state 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1; rand_out 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1,0.
- Word mode, OUT_W=2, FILL_WORDS=4: fill_start, word_ready=1 -> word_out 00,01,00,11 at word_idx 0..3; fill_busy for 4 cycles; fill_done pulses 1 cycle; final state 4'h5.
- Backpressure, same config: word_ready low for 3 cycles at word_idx=1 -> word_out holds 01, word_idx holds 1; resumes with 00 then 11 after ready returns.
- Seed handling: seed_load=1 with seed_in=4'h0 -> state=1. seed_load with seed_in=4'h9 during FILL at word_idx=2 -> next cycle IDLE, word_valid=0, state=9, no fill_done.
- Async reset: assert rst mid-clock during FILL -> outputs reach reset values before the next edge; after release, fill_start restarts from word_idx=0.
- Default config, 16-bit: free-run 65535 advances with OUT_W=1 -> state returns to 16'hACE1 on exactly that count and never equals 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random source:
// the fill FSM encoding, default primitive tap masks and the default seed.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fsm_t;

    // Maximal-length Fibonacci tap masks; bit i set feeds state[i] into the XOR.
    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hD008;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_step.sv
// One combinational Fibonacci LFSR step: shift left and insert the
// XOR-reduction of the tapped bits at bit 0.
module lfsr_step #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = 16'hD008
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] stepped
);

    logic fb;

    assign fb      = ^(cur & TAPS);
    assign stepped = {cur[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_rand_gen.sv
// Parametrised LFSR random source with seed loading, lockup guard,
// OUT_W-bit word output and a valid/ready burst fill mode.
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] TAPS       = TAPS_W16,
    parameter logic [WIDTH-1:0] SEED       = DEFAULT_SEED,
    parameter int               OUT_W      = 8,
    parameter int               FILL_WORDS = 64,
    localparam int              IDX_W      = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rand_en,
    input  logic             fill_start,
    input  logic             word_ready,
    output logic             rand_out,
    output logic [OUT_W-1:0] word_out,
    output logic             word_valid,
    output logic [IDX_W-1:0] word_idx,
    output logic             fill_busy,
    output logic             fill_done
);

    fsm_t             fsm;
    fsm_t             fsm_nxt;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] advanced;
    logic [WIDTH-1:0] advanced_safe;
    logic             handshake;
    logic             last_word;
    logic             advance;

    // OUT_W single steps chained so a whole word is produced per clock.
    for (genvar g = 0; g < OUT_W; g++) begin : g_step
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] stepped;
        if (g == 0) begin : g_first
            assign cur = state;
        end else begin : g_rest
            assign cur = g_step[g-1].stepped;
        end
        lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .cur     (cur),
            .stepped (stepped)
        );
    end

    assign advanced      = g_step[OUT_W-1].stepped;
    // Only an illegal TAPS mask can reach zero; recover rather than lock up.
    assign advanced_safe = (advanced == '0) ? SEED : advanced;

    assign handshake = (fsm == FILL) && word_ready;
    assign last_word = (word_idx == IDX_W'(FILL_WORDS - 1));
    assign advance   = ((fsm == IDLE) && rand_en) || handshake;

    assign rand_out = state[WIDTH-1];
    assign word_out = state[WIDTH-1 -: OUT_W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // NOTE: defaulting fsm_nxt before the case keeps this block latch-free.
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (fill_start) fsm_nxt = FILL;
            FILL:    if (handshake && last_word) fsm_nxt = DONE;
            DONE:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
        if (seed_load) begin
            fsm_nxt = IDLE;
        end
    end

    always_comb begin
        word_valid = (fsm == FILL);
        fill_busy  = (fsm == FILL);
        fill_done  = (fsm == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEED;
            word_idx <= '0;
        end else if (seed_load) begin
            state    <= (seed_in == '0) ? SEED : seed_in;
            word_idx <= '0;
        end else begin
            if (advance) begin
                state <= advanced_safe;
            end
            if (handshake) begin
                word_idx <= last_word ? '0 : word_idx + IDX_W'(1);
            end else if ((fsm == IDLE) && fill_start) begin
                word_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Self-checking bench: three configurations share the stimulus; each scenario
// task queues expected values and compares them as the DUT produces output.
module tb_lfsr_rand_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [3:0]  seed_in = 4'h0;
    logic [15:0] seed_in_w;
    logic        rand_en = 1'b0;
    logic        fill_start = 1'b0;
    logic        word_ready = 1'b0;

    logic        a_rand_out, a_word_valid, a_fill_busy, a_fill_done;
    logic [0:0]  a_word_out;
    logic [1:0]  a_word_idx;
    logic        b_rand_out, b_word_valid, b_fill_busy, b_fill_done;
    logic [1:0]  b_word_out;
    logic [1:0]  b_word_idx;
    logic        c_rand_out, c_word_valid, c_fill_busy, c_fill_done;
    logic [0:0]  c_word_out;
    logic [5:0]  c_word_idx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] idx;
        logic [1:0] word;
        logic       ready_next;
    } exp_word_t;

    exp_word_t  sb_word[$];
    logic [3:0] sb_state[$];
    logic       sb_bit[$];

    assign seed_in_w = {12'h000, seed_in};

    always #5 clk = ~clk;

    lfsr_rand_gen #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(1), .FILL_WORDS(4)
    ) dut_a (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .rand_en(rand_en), .fill_start(fill_start), .word_ready(word_ready),
        .rand_out(a_rand_out), .word_out(a_word_out), .word_valid(a_word_valid),
        .word_idx(a_word_idx), .fill_busy(a_fill_busy), .fill_done(a_fill_done)
    );

    lfsr_rand_gen #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(2), .FILL_WORDS(4)
    ) dut_b (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .rand_en(rand_en), .fill_start(fill_start), .word_ready(word_ready),
        .rand_out(b_rand_out), .word_out(b_word_out), .word_valid(b_word_valid),
        .word_idx(b_word_idx), .fill_busy(b_fill_busy), .fill_done(b_fill_done)
    );

    lfsr_rand_gen #(
        .WIDTH(16), .TAPS(16'hD008), .SEED(16'hACE1), .OUT_W(1), .FILL_WORDS(64)
    ) dut_c (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in_w),
        .rand_en(rand_en), .fill_start(fill_start), .word_ready(word_ready),
        .rand_out(c_rand_out), .word_out(c_word_out), .word_valid(c_word_valid),
        .word_idx(c_word_idx), .fill_busy(c_fill_busy), .fill_done(c_fill_done)
    );

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        seed_load  = 1'b0;
        seed_in    = 4'h0;
        rand_en    = 1'b0;
        fill_start = 1'b0;
        word_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (b_word_valid !== 1'b0 || b_fill_busy !== 1'b0 || b_fill_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b busy=%b done=%b expected 0 0 0",
                     b_word_valid, b_fill_busy, b_fill_done);
        end
        checks++;
        if (b_word_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_idx: got %0d expected 0", b_word_idx);
        end
        checks++;
        if (dut_b.state !== 4'h1) begin
            errors++;
            $display("FAIL reset_state4: got %h expected 1", dut_b.state);
        end
        checks++;
        if (dut_c.state !== 16'hACE1) begin
            errors++;
            $display("FAIL reset_state16: got %h expected ace1", dut_c.state);
        end
    endtask

    task automatic test_sequence();
        logic [3:0]  seq [16];
        logic [15:0] rbits;
        logic [3:0]  es;
        logic        eb;
        seq   = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                  4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        rbits = 16'b0001_0011_0101_1110;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sb_state.push_back(seq[i]);
            sb_bit.push_back(rbits[15-i]);
        end
        rand_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            es = sb_state.pop_front();
            eb = sb_bit.pop_front();
            checks++;
            if (dut_a.state !== es || a_rand_out !== eb) begin
                errors++;
                $display("FAIL seq[%0d]: got state=%h bit=%b expected state=%h bit=%b",
                         i, dut_a.state, a_rand_out, es, eb);
            end
        end
        rand_en = 1'b0;
    endtask

    task automatic test_fill();
        exp_word_t e;
        int        busy_cycles = 0;
        do_reset();
        sb_word.push_back('{2'd0, 2'b00, 1'b1});
        sb_word.push_back('{2'd1, 2'b01, 1'b1});
        sb_word.push_back('{2'd2, 2'b00, 1'b1});
        sb_word.push_back('{2'd3, 2'b11, 1'b1});
        fill_start = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            e = sb_word.pop_front();
            if (b_fill_busy === 1'b1) busy_cycles++;
            checks++;
            if (b_word_valid !== 1'b1 || b_word_idx !== e.idx || b_word_out !== e.word) begin
                errors++;
                $display("FAIL fill_word[%0d]: got valid=%b idx=%0d word=%b expected 1 %0d %b",
                         k, b_word_valid, b_word_idx, b_word_out, e.idx, e.word);
            end
        end
        @(negedge clk);
        checks++;
        if (b_fill_done !== 1'b1 || b_fill_busy !== 1'b0 || b_word_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_done_pulse: got done=%b busy=%b valid=%b expected 1 0 0",
                     b_fill_done, b_fill_busy, b_word_valid);
        end
        checks++;
        if (dut_b.state !== 4'h5) begin
            errors++;
            $display("FAIL fill_final_state: got %h expected 5", dut_b.state);
        end
        checks++;
        if (busy_cycles != 4) begin
            errors++;
            $display("FAIL fill_busy_cycles: got %0d expected 4", busy_cycles);
        end
        @(negedge clk);
        checks++;
        if (b_fill_done !== 1'b0 || b_word_idx !== 2'd0) begin
            errors++;
            $display("FAIL fill_done_width: got done=%b idx=%0d expected 0 0", b_fill_done, b_word_idx);
        end
        word_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_word_t e;
        do_reset();
        sb_word.push_back('{2'd0, 2'b00, 1'b1});
        sb_word.push_back('{2'd1, 2'b01, 1'b0});
        sb_word.push_back('{2'd1, 2'b01, 1'b0});
        sb_word.push_back('{2'd1, 2'b01, 1'b0});
        sb_word.push_back('{2'd1, 2'b01, 1'b1});
        sb_word.push_back('{2'd2, 2'b00, 1'b1});
        sb_word.push_back('{2'd3, 2'b11, 1'b1});
        fill_start = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            e = sb_word.pop_front();
            checks++;
            if (b_word_valid !== 1'b1 || b_word_idx !== e.idx || b_word_out !== e.word) begin
                errors++;
                $display("FAIL bp_word[%0d]: got valid=%b idx=%0d word=%b expected 1 %0d %b",
                         k, b_word_valid, b_word_idx, b_word_out, e.idx, e.word);
            end
            word_ready = e.ready_next;
            @(negedge clk);
        end
        checks++;
        if (b_fill_done !== 1'b1 || dut_b.state !== 4'h5) begin
            errors++;
            $display("FAIL bp_done: got done=%b state=%h expected 1 5", b_fill_done, dut_b.state);
        end
        word_ready = 1'b0;
    endtask

    task automatic test_seed();
        do_reset();
        rand_en = 1'b1;
        repeat (3) @(negedge clk);
        rand_en = 1'b0;
        checks++;
        if (dut_b.state !== 4'hD) begin
            errors++;
            $display("FAIL seed_prerun: got %h expected d", dut_b.state);
        end
        seed_load = 1'b1;
        seed_in   = 4'h0;
        @(negedge clk);
        seed_load = 1'b0;
        checks++;
        if (dut_b.state !== 4'h1) begin
            errors++;
            $display("FAIL seed_zero_fallback: got %h expected 1", dut_b.state);
        end
        fill_start = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (b_word_idx !== 2'd2 || b_word_valid !== 1'b1) begin
            errors++;
            $display("FAIL seed_fill_pos: got idx=%0d valid=%b expected 2 1", b_word_idx, b_word_valid);
        end
        seed_load = 1'b1;
        seed_in   = 4'h9;
        @(negedge clk);
        seed_load = 1'b0;
        checks++;
        if (b_word_valid !== 1'b0 || b_fill_busy !== 1'b0 || b_word_idx !== 2'd0 ||
            b_fill_done !== 1'b0 || dut_b.state !== 4'h9) begin
            errors++;
            $display("FAIL seed_abort: got valid=%b busy=%b idx=%0d done=%b state=%h expected 0 0 0 0 9",
                     b_word_valid, b_fill_busy, b_word_idx, b_fill_done, dut_b.state);
        end
        @(negedge clk);
        checks++;
        if (b_fill_done !== 1'b0 || b_word_valid !== 1'b0) begin
            errors++;
            $display("FAIL seed_abort_no_done: got done=%b valid=%b expected 0 0", b_fill_done, b_word_valid);
        end
        seed_load  = 1'b1;
        seed_in    = 4'h6;
        fill_start = 1'b1;
        @(negedge clk);
        seed_load  = 1'b0;
        fill_start = 1'b0;
        checks++;
        if (b_fill_busy !== 1'b0 || dut_b.state !== 4'h6) begin
            errors++;
            $display("FAIL seed_beats_start: got busy=%b state=%h expected 0 6", b_fill_busy, dut_b.state);
        end
        word_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_start = 1'b1;
        word_ready = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (b_word_valid !== 1'b0 || b_fill_busy !== 1'b0 || b_word_idx !== 2'd0 ||
            dut_b.state !== 4'h1) begin
            errors++;
            $display("FAIL async_reset: got valid=%b busy=%b idx=%0d state=%h expected 0 0 0 1",
                     b_word_valid, b_fill_busy, b_word_idx, dut_b.state);
        end
        @(negedge clk);
        rst        = 1'b0;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        checks++;
        if (b_word_valid !== 1'b1 || b_word_idx !== 2'd0 || b_word_out !== 2'b00) begin
            errors++;
            $display("FAIL async_restart: got valid=%b idx=%0d word=%b expected 1 0 00",
                     b_word_valid, b_word_idx, b_word_out);
        end
        word_ready = 1'b0;
    endtask

    task automatic test_period16();
        int first_hit = 0;
        int zero_seen = 0;
        do_reset();
        rand_en = 1'b1;
        for (int n = 1; n <= 65535; n++) begin
            @(negedge clk);
            if (dut_c.state == 16'h0000) zero_seen++;
            if (first_hit == 0 && dut_c.state == 16'hACE1) first_hit = n;
        end
        rand_en = 1'b0;
        checks++;
        if (first_hit != 65535) begin
            errors++;
            $display("FAIL period16: got first return at %0d expected 65535", first_hit);
        end
        checks++;
        if (zero_seen != 0) begin
            errors++;
            $display("FAIL period16_zero: got %0d zero states expected 0", zero_seen);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_fill();
        test_backpressure();
        test_seed();
        test_async_reset();
        test_period16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
